// File: rtl/wishbone_controller_arbiter_pkg.sv
// Shared WishboneInterconnect definitions: arbitration mode codes and the
// select-index to one-hot conversion used by the arbiter and its callers.
package wishbone_controller_arbiter_pkg;

    localparam int ARB_MODE_ROUND_ROBIN = 0;
    localparam int ARB_MODE_FIXED       = 1;
    localparam int MAX_CONTROLLERS      = 16;

    typedef enum logic [0:0] {
        ARB_RR    = 1'b0,
        ARB_FIXED = 1'b1
    } arb_mode_e;

    // Callers truncate the result to their own controller count.
    function automatic logic [MAX_CONTROLLERS-1:0] sel_to_onehot(input int unsigned sel);
        logic [MAX_CONTROLLERS-1:0] v;
        v = {{(MAX_CONTROLLERS-1){1'b0}}, 1'b1} << sel;
        return v;
    endfunction

endpackage

// File: rtl/wishbone_controller_arbiter_if.sv
// Bus-ownership handshake between the controller ports and the arbiter.
// The arbiter takes the slave view; the controller side takes the master view.
interface wishbone_controller_arbiter_if #(
    parameter int CONTROLLER_COUNT = 4,
    parameter int SELECT_WIDTH     = $clog2(CONTROLLER_COUNT)
);
    logic [CONTROLLER_COUNT-1:0] request;
    logic                        transferDone;
    logic [SELECT_WIDTH-1:0]     controllerSelected;
    logic [CONTROLLER_COUNT-1:0] grant;
    logic                        grantValid;

    modport master (
        output request,
        output transferDone,
        input  controllerSelected,
        input  grant,
        input  grantValid
    );

    modport slave (
        input  request,
        input  transferDone,
        output controllerSelected,
        output grant,
        output grantValid
    );
endinterface

// File: rtl/wishbone_controller_arbiter_rotating_priority_encoder.sv
// Finds the first set bit of a request vector scanning upward from a start
// index with wrap-around; serves both round-robin and fixed-priority selection.
module rotating_priority_encoder #(
    parameter int N  = 4,
    parameter int SW = $clog2(N)
) (
    input  logic [N-1:0]  i_request,
    input  logic [SW-1:0] i_start,
    output logic [SW-1:0] o_index,
    output logic          o_found
);

    int unsigned w_pos;

    // Wrap-around scan, first hit wins.
    always_comb begin
        o_index = '0;
        o_found = 1'b0;
        w_pos   = 0;
        for (int k = 0; k < N; k++) begin
            w_pos = (int'(i_start) + k) % N;
            if (!o_found && i_request[w_pos]) begin
                o_found = 1'b1;
                o_index = SW'(w_pos);
            end else begin
                o_found = o_found;
            end
        end
    end

endmodule

// File: rtl/wishbone_controller_arbiter.sv
// Shared-bus arbiter: combinational owner selection (round-robin or fixed
// priority) with an optional per-tenure transfer quota forcing a yield.
module wishbone_controller_arbiter
    import wishbone_controller_arbiter_pkg::*;
#(
    parameter int CONTROLLER_COUNT = 4,
    parameter int SELECT_WIDTH     = $clog2(CONTROLLER_COUNT),
    parameter int ARBITRATION_MODE = ARB_MODE_ROUND_ROBIN,
    parameter int MAX_TRANSFERS    = 0,
    parameter int COUNT_WIDTH      = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    wishbone_controller_arbiter_if.slave bus
);

    localparam bit QUOTA_EN = (MAX_TRANSFERS != 0);
    localparam logic [COUNT_WIDTH-1:0] QUOTA_LAST =
        QUOTA_EN ? COUNT_WIDTH'(MAX_TRANSFERS - 1) : '0;
    localparam logic [SELECT_WIDTH-1:0] LAST_INDEX = SELECT_WIDTH'(CONTROLLER_COUNT - 1);
    localparam arb_mode_e MODE =
        (ARBITRATION_MODE == ARB_MODE_FIXED) ? ARB_FIXED : ARB_RR;

    logic [SELECT_WIDTH-1:0]     r_current;
    logic [COUNT_WIDTH-1:0]      r_count;
    logic                        r_yield_pending;

    logic [CONTROLLER_COUNT-1:0] w_cur_onehot;
    logic [CONTROLLER_COUNT-1:0] w_next_onehot;
    logic [CONTROLLER_COUNT-1:0] w_others_req;
    logic                        w_others;
    logic                        w_owner_req;
    logic [SELECT_WIDTH-1:0]     w_start;
    logic [SELECT_WIDTH-1:0]     w_candidate;
    logic                        w_cand_found;
    logic [SELECT_WIDTH-1:0]     w_next;
    logic                        w_change;
    logic                        w_counted_done;

    assign w_cur_onehot  = CONTROLLER_COUNT'(sel_to_onehot(32'(r_current)));
    assign w_next_onehot = CONTROLLER_COUNT'(sel_to_onehot(32'(w_next)));
    assign w_others_req  = bus.request & ~w_cur_onehot;
    assign w_others      = |w_others_req;
    assign w_owner_req   = bus.request[r_current];

    // Round-robin scans from the index after the owner; fixed priority from 0.
    always_comb begin
        w_start = '0;
        if (MODE == ARB_RR) begin
            if (r_current == LAST_INDEX) begin
                w_start = '0;
            end else begin
                w_start = r_current + 1'b1;
            end
        end else begin
            w_start = '0;
        end
    end

    rotating_priority_encoder #(
        .N  (CONTROLLER_COUNT),
        .SW (SELECT_WIDTH)
    ) u_encoder (
        .i_request (w_others_req),
        .i_start   (w_start),
        .o_index   (w_candidate),
        .o_found   (w_cand_found)
    );

    // Owner keeps the bus unless it stopped requesting or owes a quota yield.
    always_comb begin
        w_next = r_current;
        if (w_owner_req && !(r_yield_pending && w_others)) begin
            w_next = r_current;
        end else if (w_others && w_cand_found) begin
            w_next = w_candidate;
        end else begin
            w_next = r_current;
        end
    end

    assign w_change       = (w_next != r_current);
    assign w_counted_done = bus.transferDone && w_owner_req;

    // Reset forces the bus-facing outputs low and releases them as soon as it falls.
    assign bus.controllerSelected = rst ? '0 : w_next;
    assign bus.grant              = rst ? '0 : (w_next_onehot & bus.request);
    assign bus.grantValid         = rst ? 1'b0 : bus.request[w_next];

    // Owner index follows the combinational decision.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_current <= '0;
        end else begin
            r_current <= w_next;
        end
    end

    // Per-tenure completed-transfer counter, saturating.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (w_change) begin
            r_count <= '0;
        end else if (w_counted_done && (r_count != '1)) begin
            r_count <= r_count + 1'b1;
        end else begin
            r_count <= r_count;
        end
    end

    // Yield owed once the quota is reached; cleared by a hand-over or a dropped request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_yield_pending <= 1'b0;
        end else if (w_change || !w_owner_req) begin
            r_yield_pending <= 1'b0;
        end else if (QUOTA_EN && w_counted_done && (r_count == QUOTA_LAST)) begin
            r_yield_pending <= 1'b1;
        end else begin
            r_yield_pending <= r_yield_pending;
        end
    end

endmodule

// File: tb/tb_wishbone_controller_arbiter.sv
// Bench for wishbone_controller_arbiter: a round-robin and a fixed-priority
// instance (quota 2) share stimulus and are checked against a reference model.
module tb_wishbone_controller_arbiter;

    localparam int N    = 4;
    localparam int MAXT = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = 4'b1111;
    logic       done = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    wishbone_controller_arbiter_if #(.CONTROLLER_COUNT(N)) if_rr ();
    wishbone_controller_arbiter_if #(.CONTROLLER_COUNT(N)) if_fx ();

    assign if_rr.request      = req;
    assign if_rr.transferDone = done;
    assign if_fx.request      = req;
    assign if_fx.transferDone = done;

    wishbone_controller_arbiter #(
        .CONTROLLER_COUNT (N), .ARBITRATION_MODE (0),
        .MAX_TRANSFERS (MAXT), .COUNT_WIDTH (8)
    ) dut_rr (.clk (clk), .rst (rst), .bus (if_rr.slave));

    wishbone_controller_arbiter #(
        .CONTROLLER_COUNT (N), .ARBITRATION_MODE (1),
        .MAX_TRANSFERS (MAXT), .COUNT_WIDTH (8)
    ) dut_fx (.clk (clk), .rst (rst), .bus (if_fx.slave));

    always #5 clk = ~clk;

    logic [1:0] obs_sel [2];
    logic [3:0] obs_gnt [2];
    logic       obs_gv  [2];
    assign obs_sel[0] = if_rr.controllerSelected;
    assign obs_sel[1] = if_fx.controllerSelected;
    assign obs_gnt[0] = if_rr.grant;
    assign obs_gnt[1] = if_fx.grant;
    assign obs_gv[0]  = if_rr.grantValid;
    assign obs_gv[1]  = if_fx.grantValid;

    // Reference model: owner, transfers this tenure, yield owed.
    int m_cur   [2] = '{0, 0};
    int m_cnt   [2] = '{0, 0};
    bit m_yield [2] = '{0, 0};
    int m_mode  [2] = '{0, 1};

    function automatic int m_next(input int d, input logic [3:0] r);
        int  cur;
        bit  others;
        cur = m_cur[d];
        others = 1'b0;
        for (int i = 0; i < N; i++) if (i != cur && r[i]) others = 1'b1;
        if (r[cur] && !(m_yield[d] && others)) return cur;
        if (!others) return cur;
        if (m_mode[d] == 0) begin
            for (int k = 1; k < N; k++) if (r[(cur + k) % N]) return (cur + k) % N;
        end else begin
            for (int i = 0; i < N; i++) if (i != cur && r[i]) return i;
        end
        return cur;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        int nx;
        logic [3:0] eg;
        for (int d = 0; d < 2; d++) begin
            nx = m_next(d, req);
            eg = 4'b0000;
            if (!rst && req[nx]) eg[nx] = 1'b1;
            chk($sformatf("model_sel%0d", d), 32'(obs_sel[d]), rst ? 32'd0 : 32'(nx));
            chk($sformatf("model_gnt%0d", d), 32'(obs_gnt[d]), 32'(eg));
            chk($sformatf("model_gv%0d", d),  32'(obs_gv[d]),  rst ? 32'd0 : 32'(req[nx]));
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_cur[d] = 0; m_cnt[d] = 0; m_yield[d] = 1'b0;
        end
    endtask

    task automatic model_clock();
        int nx;
        if (rst) begin
            model_reset();
        end else begin
            for (int d = 0; d < 2; d++) begin
                nx = m_next(d, req);
                if (nx != m_cur[d]) begin
                    m_cur[d] = nx; m_cnt[d] = 0; m_yield[d] = 1'b0;
                end else if (!req[m_cur[d]]) begin
                    m_yield[d] = 1'b0;
                end else if (done) begin
                    if (m_cnt[d] == MAXT - 1) m_yield[d] = 1'b1;
                    if (m_cnt[d] < 255) m_cnt[d] = m_cnt[d] + 1;
                end
            end
        end
    endtask

    // Check outputs mid-cycle, advance the model, then cross one clock edge.
    task automatic step();
        #1;
        check_all();
        model_clock();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        // Reset holds every output at zero regardless of requests.
        req = 4'b1111;
        #1;
        chk("rst_sel", 32'(obs_sel[0]), 32'd0);
        chk("rst_gnt", 32'(obs_gnt[0]), 32'd0);
        chk("rst_gv",  32'(obs_gv[0]),  32'd0);
        step();
        rst = 1'b0;
        #1;
        chk("rel_sel", 32'(obs_sel[0]), 32'd0);
        chk("rel_gnt", 32'(obs_gnt[0]), 32'h1);
        step();

        // Round-robin rotation: owner 1 drops, 3 takes over, then wraps to 0.
        req = 4'b0010; step();
        req = 4'b1011; step();
        req = 4'b1001; #1;
        chk("rr_drop1_sel", 32'(obs_sel[0]), 32'd3);
        chk("fx_drop1_sel", 32'(obs_sel[1]), 32'd0);
        step();
        req = 4'b0001; #1;
        chk("rr_wrap_sel", 32'(obs_sel[0]), 32'd0);
        step();

        // Quota of two with a competitor waiting: yield one cycle after the second ack.
        req = 4'b0101; done = 1'b1; #1;
        chk("q_ack1_sel", 32'(obs_sel[0]), 32'd0);
        step();
        #1;
        chk("q_ack2_sel", 32'(obs_sel[0]), 32'd0);
        step();
        done = 1'b0; #1;
        chk("q_yield_rr", 32'(obs_sel[0]), 32'd2);
        chk("q_yield_fx", 32'(obs_sel[1]), 32'd2);
        step();

        // Quota reached with nobody waiting: owner keeps the bus until 2 requests.
        req = 4'b0001; step();
        done = 1'b1; step();
        step();
        done = 1'b0; #1;
        chk("q_alone_keep", 32'(obs_sel[0]), 32'd0);
        step(); step();
        req = 4'b0101; #1;
        chk("q_late_yield", 32'(obs_sel[0]), 32'd2);
        step();

        // Fixed priority: owner 3 drops, 1 wins, a later request 0 does not preempt.
        req = 4'b1000; step();
        req = 4'b1110; step();
        req = 4'b0110; #1;
        chk("fx_drop3_sel", 32'(obs_sel[1]), 32'd1);
        step();
        req = 4'b0111; #1;
        chk("fx_nopreempt", 32'(obs_sel[1]), 32'd1);
        step();

        // Async reset mid-tenure discards the partial count.
        req = 4'b0001; step();
        done = 1'b1; step();
        done = 1'b0;
        rst = 1'b1; #1;
        chk("arst_sel", 32'(obs_sel[0]), 32'd0);
        chk("arst_gnt", 32'(obs_gnt[0]), 32'd0);
        chk("arst_gv",  32'(obs_gv[0]),  32'd0);
        #1;
        rst = 1'b0;
        model_reset();
        req = 4'b0101; done = 1'b1; step();
        done = 1'b0; #1;
        chk("arst_noyield", 32'(obs_sel[0]), 32'd0);
        step();

        // Randomised traffic against the model, with occasional synchronous-length resets.
        for (int i = 0; i < 400; i++) begin
            req  = 4'($urandom_range(0, 15));
            done = 1'($urandom_range(0, 1));
            rst  = ($urandom_range(0, 49) == 0);
            step();
        end
        rst = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
